neuron_mac_stream: RTL and testbench
====================================

Name: neuron_mac_stream

Overview:
- Parametrised streaming successor to the flat-bus neuron dot-product block.
- Accepts LANES weight/pixel pairs per beat over a valid/ready handshake and accumulates VEC_LEN products into a wide accumulator.
- Adds a signed bias, applies an optional arithmetic shift and ReLU, saturates to OW bits, then holds the result until downstream accepts it.
- Sits between the weight/pixel fetch logic and the argmax/classifier stage; one instance per neuron.

Parameters:
- LANES, 2: multipliers per beat.
- VEC_LEN, 785: products per neuron vector.
- WW, 19: weight width, signed two's complement.
- PW, 10: pixel width, unsigned.
- ACC_W, 40: accumulator width, signed; must be at least WW+PW+1+clog2(VEC_LEN).
- OW, 26: output width, signed.
- FRAC_SHIFT, 0: arithmetic right shift applied before saturation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept; a beat transfers when in_valid && in_ready.
- in_wgt  in  LANES*WW  lane k occupies bits [k*WW +: WW].
- in_pix  in  LANES*PW  lane k occupies bits [k*PW +: PW].
- bias  in  OW  signed; sampled on the first beat of a vector.
- relu_en  in  1  sampled on the first beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_neuron  out  OW  signed result.
- out_sat  out  1  set when saturation clipped this result.

Behaviour:
- Reset (rst=0, asynchronous): in_ready=0, out_valid=0, out_neuron=0, out_sat=0. FSM goes to IDLE; accumulator, beat counter and pipeline valid bits clear. Any partial vector is discarded. in_ready rises on the first clk edge after rst deasserts.
- BEATS = ceil(VEC_LEN/LANES). Lane k of beat b carries element b*LANES+k. On the last beat, lanes whose element index is >= VEC_LEN are forced to a zero product, whatever their data.
- FSM states:
  - IDLE: in_ready=1. First accepted beat: clear accumulator, latch bias and relu_en, beat_cnt=1, go to ACCUM. If BEATS=1, go to DRAIN instead.
  - ACCUM: in_ready=1. Each accepted beat increments beat_cnt. The accepted beat with beat_cnt==BEATS-1 is the last; go to DRAIN. in_valid gaps are allowed and insert no products.
  - DRAIN: in_ready=0. Wait until the pipeline valid tags are empty, then register the result and go to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_neuron and out_sat stay stable until out_valid && out_ready. On handshake: out_valid=0, go to IDLE; in_ready=1 in the following cycle.
- Pipeline (each stage carries a valid tag):
  - S1 registers the LANES products. Each pixel is zero-extended, then multiplied signed; product width WW+PW+1.
  - S2 registers the lane-sum adder tree.
  - S3 sign-extends into the accumulator.
- Finalisation, one registered stage: take acc plus bias sign-extended to ACC_W, shift right arithmetically by FRAC_SHIFT, then:
  - if relu_en and the value is negative, the result is 0 with out_sat=0;
  - otherwise clamp to [-2^(OW-1), 2^(OW-1)-1], and set out_sat=1 if clamped.
- Latency, stall-free: out_valid rises exactly 4 clk edges after the edge that accepts the last beat.
- Accumulator overflow cannot occur given the ACC_W constraint; elaboration fails if the constraint is violated.
- in_valid during DRAIN or HOLD is ignored. The source must hold the beat until in_ready is high.
- Vectors never overlap; throughput is one vector per BEATS+5 cycles minimum.

Decomposition:
- Package neuron_pkg holds:
  - default widths (WW, PW, OW, ACC_W);
  - the state enum {IDLE, ACCUM, DRAIN, HOLD};
  - the clog2 and ceil-divide constant functions;
  - the saturate/ReLU constant helpers.
- Sub-module neuron_lane_tree, parametrised on LANES, WW and PW, contains:
  - lane masking, the multipliers and the registered adder tree (stages S1 and S2);
  - valid-tag propagation.
- The top level keeps the FSM, beat counter, accumulator, finalisation and output handshake.

Test Plan:
1. Defaults, all weights=1, pixels=1, bias=0, relu_en=0, out_ready=1 -> out_neuron=785, out_sat=0; out_valid 4 edges after the last beat, high for one cycle.
2. Masking: all lanes zero except last beat lane 1 (element 785) with wgt=262143, pix=1023 -> out_neuron=0.
3. Saturation: every wgt=262143, pix=1023 -> out_neuron=33554431, out_sat=1. Every wgt=-262144 -> out_neuron=-33554432, out_sat=1.
4. ReLU/bias: every wgt=-1, pix=5, bias=25.
   - relu_en=0 -> out_neuron=-3900.
   - relu_en=1 -> out_neuron=0, out_sat=0.
5. Backpressure: case 1 with out_ready low for 10 cycles -> out_valid=1 and out_neuron=785 stable, in_ready=0 throughout; on handshake out_valid=0, in_ready=1 the next cycle.
6. Gaps/reset: case 1 with random in_valid gaps -> out_neuron=785. Assert rst=0 at beat 200 -> all outputs 0 immediately; a following full vector gives 785.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the streaming neuron MAC.
// Holds the default datapath widths, the controller state encoding, the
// constant helpers used to size counters and adder trees, and the
// saturate/ReLU helpers applied at finalisation.
package neuron_pkg;

  localparam int WW_DEF    = 19;
  localparam int PW_DEF    = 10;
  localparam int OW_DEF    = 26;
  localparam int ACC_W_DEF = 40;

  // Finalisation is evaluated at this fixed width so the helpers below need
  // no width parameters; ACC_W must not exceed it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_hi(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_lo(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

  // ReLU takes precedence: a negative value under ReLU becomes 0 and is not
  // reported as clipped.
  function automatic logic signed [MAX_W-1:0] sat_value(
    input logic signed [MAX_W-1:0] v, input int ow, input logic relu);
    if (relu && v < 0)      return '0;
    else if (v > sat_hi(ow)) return sat_hi(ow);
    else if (v < sat_lo(ow)) return sat_lo(ow);
    else                     return v;
  endfunction

  function automatic logic sat_flag(
    input logic signed [MAX_W-1:0] v, input int ow, input logic relu);
    if (relu && v < 0) return 1'b0;
    return (v > sat_hi(ow)) || (v < sat_lo(ow));
  endfunction

endpackage

// File: rtl/neuron_lane_tree.sv
// Lane multipliers and lane-sum stage of the neuron MAC.
//   clk, rst       : clock, asynchronous active-low reset
//   beat_fire      : a beat is accepted this cycle
//   lane_en        : per-lane enable; disabled lanes contribute a zero product
//   wgt / pix      : packed lane data, lane k at [k*WW +: WW] / [k*PW +: PW]
//   sum_valid, sum : S2 output, lane sum tagged valid
//   busy           : S1 or S2 still holds a valid beat
module neuron_lane_tree
  import neuron_pkg::*;
#(
  parameter int LANES = 2,
  parameter int WW = WW_DEF,
  parameter int PW = PW_DEF,
  localparam int PROD_W = WW + PW + 1,
  localparam int SUM_W = PROD_W + clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    beat_fire,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*WW-1:0]     wgt,
  input  logic [LANES*PW-1:0]     pix,
  output logic                    sum_valid,
  output logic signed [SUM_W-1:0] sum,
  output logic                    busy
);

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  sum_d;
  logic                     s1_valid;
  logic                     s2_valid;

  // Pixels are unsigned: a zero MSB makes them non-negative signed operands.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = '0;
      if (lane_en[k])
        prod_d[k] = PROD_W'($signed(wgt[k*WW +: WW])) *
                    PROD_W'($signed({1'b0, pix[k*PW +: PW]}));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++)
      sum_d = sum_d + SUM_W'(prod_q[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      sum      <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      s1_valid <= beat_fire;
      s2_valid <= s1_valid;
      if (beat_fire)
        for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
      if (s1_valid)
        sum <= sum_d;
    end
  end

  assign sum_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: rtl/neuron_mac_stream.sv
// Streaming neuron dot-product: LANES weight/pixel pairs per beat, VEC_LEN
// products per vector, plus bias, shift, optional ReLU and saturation.
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid/in_ready     : beat handshake
//   in_wgt, in_pix        : packed lane data
//   bias, relu_en         : sampled on the first beat of a vector
//   out_valid/out_ready   : result handshake
//   out_neuron, out_sat   : signed result and clip flag, held until accepted
//
// state | meaning
// IDLE  | waiting for the first beat of a vector
// ACCUM | accepting the remaining beats
// DRAIN | last beat taken, waiting for the pipeline to empty
// HOLD  | result presented until downstream accepts
module neuron_mac_stream
  import neuron_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int VEC_LEN    = 785,
  parameter int WW         = WW_DEF,
  parameter int PW         = PW_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OW         = OW_DEF,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*WW-1:0]  in_wgt,
  input  logic [LANES*PW-1:0]  in_pix,
  input  logic signed [OW-1:0] bias,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_neuron,
  output logic                 out_sat
);

  localparam int BEATS      = ceil_div(VEC_LEN, LANES);
  localparam int BCW        = clog2(BEATS + 1);
  localparam int LAST_LANES = VEC_LEN - (BEATS - 1) * LANES;
  localparam int SUM_W      = WW + PW + 1 + clog2(LANES);

  generate
    if (ACC_W < WW + PW + 1 + clog2(VEC_LEN) || ACC_W > MAX_W) begin : g_acc_w_bad
      $error("neuron_mac_stream: ACC_W too small for VEC_LEN products or wider than MAX_W");
    end
  endgenerate

  state_t                    state_q, state_d;
  logic                      armed_q;
  logic [BCW-1:0]            beat_cnt;
  logic                      beat_fire, first_beat, last_sel, last_beat;
  logic [LANES-1:0]          lane_en;
  logic                      tree_valid, tree_busy;
  logic signed [SUM_W-1:0]   tree_sum;
  logic                      s3_valid;
  logic signed [ACC_W-1:0]   s3_data;
  logic signed [ACC_W-1:0]   acc;
  logic signed [OW-1:0]      bias_q;
  logic                      relu_q;
  logic                      pipe_empty;
  logic signed [ACC_W-1:0]   fin_sum, fin_shift;
  logic signed [MAX_W-1:0]   fin_wide, res_wide;
  logic                      res_sat;

  assign beat_fire  = in_valid && in_ready;
  assign first_beat = beat_fire && (state_q == IDLE);
  assign last_sel   = ((state_q == IDLE) && (BEATS == 1)) ||
                      ((state_q == ACCUM) && (beat_cnt == BCW'(BEATS - 1)));
  assign last_beat  = beat_fire && last_sel;
  assign pipe_empty = !tree_busy && !s3_valid;

  // Only the last beat can carry lanes beyond the vector end.
  always_comb begin
    lane_en = '1;
    if (last_sel)
      for (int k = 0; k < LANES; k++) lane_en[k] = (k < LAST_LANES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (beat_fire) state_d = (BEATS == 1) ? DRAIN : ACCUM;
      ACCUM: if (last_beat) state_d = DRAIN;
      DRAIN: if (pipe_empty) state_d = HOLD;
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // armed_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = armed_q && ((state_q == IDLE) || (state_q == ACCUM));
    out_valid = (state_q == HOLD);
  end

  neuron_lane_tree #(
    .LANES(LANES),
    .WW(WW),
    .PW(PW)
  ) u_lane_tree (
    .clk(clk),
    .rst(rst),
    .beat_fire(beat_fire),
    .lane_en(lane_en),
    .wgt(in_wgt),
    .pix(in_pix),
    .sum_valid(tree_valid),
    .sum(tree_sum),
    .busy(tree_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      s3_valid <= 1'b0;
      s3_data  <= '0;
      acc      <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
    end else begin
      if (first_beat)
        beat_cnt <= BCW'(1);
      else if (beat_fire)
        beat_cnt <= beat_cnt + BCW'(1);

      s3_valid <= tree_valid;
      if (tree_valid)
        s3_data <= ACC_W'(tree_sum);

      // The previous vector has fully drained before a first beat is taken,
      // so clearing here never drops a pending product.
      if (first_beat)
        acc <= '0;
      else if (s3_valid)
        acc <= acc + s3_data;

      if (first_beat) begin
        bias_q <= bias;
        relu_q <= relu_en;
      end
    end
  end

  always_comb begin
    fin_sum   = acc + ACC_W'(bias_q);
    fin_shift = fin_sum >>> FRAC_SHIFT;
    fin_wide  = MAX_W'(fin_shift);
    res_wide  = sat_value(fin_wide, OW, relu_q);
    res_sat   = sat_flag(fin_wide, OW, relu_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_neuron <= '0;
      out_sat    <= 1'b0;
    end else if ((state_q == DRAIN) && pipe_empty) begin
      out_neuron <= OW'(res_wide);
      out_sat    <= res_sat;
    end
  end

endmodule

// File: tb/tb_neuron_mac_stream.sv
module tb_neuron_mac_stream;
  localparam int LANES   = 2;
  localparam int VEC_LEN = 785;
  localparam int WW      = 19;
  localparam int PW      = 10;
  localparam int OW      = 26;
  localparam int BEATS   = (VEC_LEN + LANES - 1) / LANES;
  localparam int ELEMS   = BEATS * LANES;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES*WW-1:0]  in_wgt = '0;
  logic [LANES*PW-1:0]  in_pix = '0;
  logic signed [OW-1:0] bias = '0;
  logic                 relu_en = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out_neuron;
  logic                 out_sat;

  neuron_mac_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wgt(in_wgt), .in_pix(in_pix),
    .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neuron(out_neuron), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint neuron;
    bit     sat;
  } exp_t;

  typedef struct {
    string  name;
    int     wgt;
    int     pix;
    int     bias;
    bit     relu;
    bit     mask_only;
    longint exp_n;
    bit     exp_s;
  } vec_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     vw[ELEMS];
  int     vp[ELEMS];
  int     last_acc_cyc = 0;
  int     ov_high_cycles = 0;
  string  cur_name = "reset";
  logic   ov_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", cur_name, name, act, exp);
    end
  endtask

  function automatic exp_t model(input int b, input bit relu);
    exp_t   e;
    longint s;
    longint hi = 33554431;
    longint lo = -33554432;
    s = b;
    for (int i = 0; i < VEC_LEN; i++) s += longint'(vw[i]) * longint'(vp[i]);
    e.sat = 1'b0;
    if (relu && s < 0) e.neuron = 0;
    else if (s > hi) begin e.neuron = hi; e.sat = 1'b1; end
    else if (s < lo) begin e.neuron = lo; e.sat = 1'b1; end
    else e.neuron = s;
    return e;
  endfunction

  function automatic void fill(input int w, input int p, input bit mask_only);
    for (int i = 0; i < ELEMS; i++) begin
      if (mask_only) begin
        vw[i] = (i == VEC_LEN) ? w : 0;
        vp[i] = (i == VEC_LEN) ? p : 0;
      end else begin
        vw[i] = w;
        vp[i] = p;
      end
    end
  endfunction

  // Drives one vector beat by beat; bias/relu_en carry junk after the first
  // beat since only the first beat should be sampled. abort_at >= 0 asserts
  // reset just before that beat and checks the reset output state.
  task automatic send_vector(input int b, input bit relu, input bit gaps,
                             input int abort_at, input exp_t e);
    int n;
    for (int bt = 0; bt < BEATS; bt++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (bt == abort_at) begin
        in_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_neuron", out_neuron, 0);
        check("rst_out_sat", out_sat, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      in_valid = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        in_wgt[k*WW +: WW] = WW'(vw[bt*LANES + k]);
        in_pix[k*PW +: PW] = PW'(vp[bt*LANES + k]);
      end
      bias    = (bt == 0) ? OW'(b) : OW'($urandom);
      relu_en = (bt == 0) ? relu : 1'($urandom);
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      if (bt == BEATS - 1) sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (bt == BEATS - 1) last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (out_valid && !ov_prev) check("latency", cyc - last_acc_cyc, 4);
      if (out_valid) ov_high_cycles++;
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_neuron", out_neuron, e.neuron);
          check("out_sat", out_sat, e.sat);
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  vec_t tbl[8];
  exp_t e;

  initial begin
    tbl[0] = '{"ones",        1,       1,    0,    0, 0, 785,       0};
    tbl[1] = '{"mask",        262143,  1023, 0,    0, 1, 0,         0};
    tbl[2] = '{"sat_pos",     262143,  1023, 0,    0, 0, 33554431,  1};
    tbl[3] = '{"sat_neg",     -262144, 1023, 0,    0, 0, -33554432, 1};
    tbl[4] = '{"bias_norelu", -1,      5,    25,   0, 0, -3900,     0};
    tbl[5] = '{"bias_relu",   -1,      5,    25,   1, 0, 0,         0};
    tbl[6] = '{"mixed",       2,       3,    -100, 0, 0, 4610,      0};
    tbl[7] = '{"relu_pos",    2,       3,    -100, 1, 0, 4610,      0};

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_neuron", out_neuron, 0);
    check("reset_out_sat", out_sat, 0);
    rst = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_edge", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      cur_name = tbl[i].name;
      fill(tbl[i].wgt, tbl[i].pix, tbl[i].mask_only);
      e.neuron = tbl[i].exp_n;
      e.sat    = tbl[i].exp_s;
      ov_high_cycles = 0;
      send_vector(tbl[i].bias, tbl[i].relu, 1'b0, -1, e);
      wait_done();
      check("out_valid_cycles", ov_high_cycles, 1);
    end

    for (int r = 0; r < 2; r++) begin
      int b;
      cur_name = (r == 0) ? "random" : "random_relu";
      for (int i = 0; i < ELEMS; i++) begin
        vw[i] = int'($urandom_range(0, 2000)) - 1000;
        vp[i] = int'($urandom_range(0, 1023));
      end
      b = int'($urandom_range(0, 200000)) - 100000;
      send_vector(b, r[0], 1'b1, -1, model(b, r[0]));
      wait_done();
    end

    cur_name = "backpressure";
    fill(1, 1, 1'b0);
    e.neuron = 785;
    e.sat    = 1'b0;
    out_ready = 1'b0;
    send_vector(0, 1'b0, 1'b0, -1, e);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_valid_rise", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_neuron", out_neuron, 785);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_after", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    wait_done();

    cur_name = "gaps";
    fill(1, 1, 1'b0);
    send_vector(0, 1'b0, 1'b1, -1, e);
    wait_done();

    cur_name = "abort";
    send_vector(0, 1'b0, 1'b0, 200, e);
    check("abort_sb_empty", sb.size(), 0);

    cur_name = "after_abort";
    send_vector(0, 1'b0, 1'b0, -1, e);
    wait_done();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
